// File: rtl/udp_cmd_pkg.sv
// Shared constants and types for the UDP command decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package udp_cmd_pkg;

  localparam logic [15:0] CMD_PORT_DEFAULT = 16'd5006;
  localparam logic [7:0]  MAGIC_DEFAULT    = 8'hA5;

  localparam int          PKT_LEN = 8;

  localparam logic [7:0]  OP_WRITE = 8'h01;
  localparam logic [7:0]  OP_READ  = 8'h02;

  localparam logic [7:0]  ACK_OK         = 8'h00;
  localparam logic [7:0]  ACK_BAD_MAGIC  = 8'h01;
  localparam logic [7:0]  ACK_BAD_OPCODE = 8'h02;
  localparam logic [7:0]  ACK_BAD_CSUM   = 8'h03;
  localparam logic [7:0]  ACK_BAD_LEN    = 8'h04;

  // PID register bank address map
  localparam logic [7:0]  REG_SETPOINT = 8'h00;
  localparam logic [7:0]  REG_KP       = 8'h01;
  localparam logic [7:0]  REG_KI       = 8'h02;
  localparam logic [7:0]  REG_KD       = 8'h03;
  localparam logic [7:0]  REG_CTRL     = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_SKIP,
    ST_CHECK,
    ST_REPORT
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/udp_cmd_wdog.sv
// Command-link watchdog: flags loss of valid commands after WDOG_CYCLES idle cycles.
// Latency: o_timeout rises the cycle after the count reaches WDOG_CYCLES-1; clears the cycle after a kick.
// Backpressure: none; i_kick is a single-cycle strobe.
// Ports: i_clk50 clock, i_rst async active-high reset, i_kick OK-packet strobe,
//        o_timeout watchdog expired level (held until kick or reset).
module udp_cmd_wdog #(
  parameter int unsigned WDOG_CYCLES = 50_000_000
) (
  input  logic i_clk50,
  input  logic i_rst,
  input  logic i_kick,
  output logic o_timeout
);

  localparam logic [25:0] LIMIT = 26'(WDOG_CYCLES - 1);

  logic [25:0] r_cnt;

  // Counter freezes once expired so the timeout level is stable until a kick.
  always_ff @(posedge i_clk50 or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= 26'd0;
      o_timeout <= 1'b0;
    end else if (i_kick) begin
      r_cnt     <= 26'd0;
      o_timeout <= 1'b0;
    end else if (!o_timeout) begin
      if (r_cnt == LIMIT) o_timeout <= 1'b1;
      else                r_cnt     <= r_cnt + 26'd1;
    end
  end

endmodule

// File: rtl/udp_cmd_decoder.sv
// Decodes 8-byte UDP command packets into PID register write/read strobes plus an ack status pulse.
// Latency: strobes/ack 2 cycles after the last payload byte (CHECK then REPORT); length errors sooner.
// Backpressure: none; the payload stream is consumed at line rate, every valid byte is accepted.
// Ports: clk50/rst (async active-high); is_udp, udp_dst_port, udp_payload[_valid|_last], frame_done
//        from the RX parser; reg_wr/reg_rd/reg_addr/reg_wdata to the PID bank; ack_valid/ack_code,
//        err_cnt and wdog_timeout to the TX ack builder.
// Option: define UDP_CMD_WDOG_EN to instantiate the command watchdog (otherwise wdog_timeout is 0).
module udp_cmd_decoder
  import udp_cmd_pkg::*;
#(
  parameter logic [15:0] CMD_PORT    = CMD_PORT_DEFAULT,
  parameter logic [7:0]  MAGIC       = MAGIC_DEFAULT,
  parameter int unsigned WDOG_CYCLES = 50_000_000
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic        is_udp,
  input  logic [15:0] udp_dst_port,
  input  logic [7:0]  udp_payload,
  input  logic        udp_payload_valid,
  input  logic        udp_payload_last,
  input  logic        frame_done,
  output logic        reg_wr,
  output logic        reg_rd,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        ack_valid,
  output logic [7:0]  ack_code,
  output logic [15:0] err_cnt,
  output logic        wdog_timeout
);

  state_t      r_state;
  logic [63:0] r_buf;
  logic [2:0]  r_cnt;      // bytes received so far; wraps only after the 8th, which leaves RECV
  logic [7:0]  r_sum;      // running sum of bytes 0..6
  logic        r_len_err;  // over-length packet seen, report at frame_done

  logic        w_port_ok;
  logic        w_last_idx;
  logic        w_rpt_trunc;
  logic [7:0]  w_magic, w_op, w_addr, w_csum;
  logic [31:0] w_data;
  logic [7:0]  w_check_code;

  assign w_port_ok   = is_udp && (udp_dst_port == CMD_PORT);
  assign w_last_idx  = (r_cnt == 3'(PKT_LEN - 1));
  // frame_done coincident with last is consumed by the last-byte path instead.
  assign w_rpt_trunc = frame_done && !(udp_payload_valid && udp_payload_last);

  assign w_magic = r_buf[63:56];
  assign w_op    = r_buf[55:48];
  assign w_addr  = r_buf[47:40];
  assign w_data  = r_buf[39:8];
  assign w_csum  = r_buf[7:0];

  always_comb begin
    w_check_code = ACK_OK;
    if (w_magic != MAGIC)                           w_check_code = ACK_BAD_MAGIC;
    else if ((w_op != OP_WRITE) && (w_op != OP_READ)) w_check_code = ACK_BAD_OPCODE;
    else if (r_sum != w_csum)                       w_check_code = ACK_BAD_CSUM;
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_buf     <= 64'd0;
      r_cnt     <= 3'd0;
      r_sum     <= 8'd0;
      r_len_err <= 1'b0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_addr  <= 8'd0;
      reg_wdata <= 32'd0;
      ack_valid <= 1'b0;
      ack_code  <= 8'd0;
      err_cnt   <= 16'd0;
    end else begin
      // Pulse outputs are set only on the transition into REPORT.
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      ack_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (udp_payload_valid) begin
            r_len_err <= 1'b0;
            if (w_port_ok) begin
              r_buf <= {56'd0, udp_payload};
              r_sum <= udp_payload;
              r_cnt <= 3'd1;
              if (udp_payload_last || frame_done) begin
                ack_valid <= 1'b1;
                ack_code  <= ACK_BAD_LEN;
                err_cnt   <= sat_inc16(err_cnt);
                r_state   <= ST_REPORT;
              end else begin
                r_state <= ST_RECV;
              end
            end else if (!frame_done) begin
              r_state <= ST_SKIP;
            end
          end
        end

        ST_RECV: begin
          if (w_rpt_trunc) begin
            ack_valid <= 1'b1;
            ack_code  <= ACK_BAD_LEN;
            err_cnt   <= sat_inc16(err_cnt);
            r_state   <= ST_REPORT;
          end else if (udp_payload_valid) begin
            r_buf <= {r_buf[55:0], udp_payload};
            r_cnt <= r_cnt + 3'd1;
            if (!w_last_idx) r_sum <= r_sum + udp_payload;
            if (udp_payload_last) begin
              if (w_last_idx) begin
                r_state <= ST_CHECK;
              end else begin
                ack_valid <= 1'b1;
                ack_code  <= ACK_BAD_LEN;
                err_cnt   <= sat_inc16(err_cnt);
                r_state   <= ST_REPORT;
              end
            end else if (w_last_idx) begin
              r_len_err <= 1'b1;
              r_state   <= ST_SKIP;
            end
          end
        end

        ST_SKIP: begin
          if (frame_done) begin
            r_len_err <= 1'b0;
            if (r_len_err) begin
              ack_valid <= 1'b1;
              ack_code  <= ACK_BAD_LEN;
              err_cnt   <= sat_inc16(err_cnt);
              r_state   <= ST_REPORT;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end

        ST_CHECK: begin
          ack_valid <= 1'b1;
          ack_code  <= w_check_code;
          if (w_check_code == ACK_OK) begin
            reg_wr    <= (w_op == OP_WRITE);
            reg_rd    <= (w_op == OP_READ);
            reg_addr  <= w_addr;
            reg_wdata <= (w_op == OP_WRITE) ? w_data : 32'd0;
          end else begin
            err_cnt <= sat_inc16(err_cnt);
          end
          r_state <= ST_REPORT;
        end

        ST_REPORT: r_state <= ST_IDLE;

        default:   r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef UDP_CMD_WDOG_EN
  logic w_ok_kick;
  assign w_ok_kick = reg_wr | reg_rd;

  udp_cmd_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .i_clk50  (clk50),
    .i_rst    (rst),
    .i_kick   (w_ok_kick),
    .o_timeout(wdog_timeout)
  );
`else
  assign wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_udp_cmd_decoder.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for udp_cmd_decoder: stimulus predicts responses from packet rules,
// a negedge monitor compares every ack pulse against the queue.
// Define UDP_CMD_WDOG_EN to also exercise the watchdog with a 100-cycle timeout.
module tb_udp_cmd_decoder;

`ifdef UDP_CMD_WDOG_EN
  localparam int unsigned TB_WDOG = 100;
`else
  localparam int unsigned TB_WDOG = 50_000_000;
`endif

  logic        clk50 = 1'b0;
  logic        rst = 1'b1;
  logic        is_udp = 1'b0;
  logic [15:0] udp_dst_port = 16'd0;
  logic [7:0]  udp_payload = 8'd0;
  logic        udp_payload_valid = 1'b0;
  logic        udp_payload_last = 1'b0;
  logic        frame_done = 1'b0;
  logic        reg_wr, reg_rd, ack_valid, wdog_timeout;
  logic [7:0]  reg_addr, ack_code;
  logic [31:0] reg_wdata;
  logic [15:0] err_cnt;

  udp_cmd_decoder #(
    .CMD_PORT(16'd5006), .MAGIC(8'hA5), .WDOG_CYCLES(TB_WDOG)
  ) dut (
    .clk50(clk50), .rst(rst), .is_udp(is_udp), .udp_dst_port(udp_dst_port),
    .udp_payload(udp_payload), .udp_payload_valid(udp_payload_valid),
    .udp_payload_last(udp_payload_last), .frame_done(frame_done),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .ack_valid(ack_valid), .ack_code(ack_code), .err_cnt(err_cnt), .wdog_timeout(wdog_timeout)
  );

  always #10 clk50 = ~clk50;

  typedef struct {
    logic [7:0]  code;
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [15:0] errc;
    int          cyc;   // expected REPORT cycle, -1 when not timed
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  fr[$];
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;
  int          model_err = 0;

  always @(posedge clk50) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: packet judged as a whole from the byte list.
  task automatic predict(input logic udp, input logic [15:0] port, input bit with_last, input int drv_cyc);
    exp_t e;
    int   s;
    if (!udp || port != 16'd5006) return;
    e = '{code: 8'h04, wr: 1'b0, rd: 1'b0, addr: 8'h00, wdata: 32'h0, errc: 16'h0, cyc: -1};
    if (fr.size() == 8 && with_last) begin
      s = 0;
      for (int i = 0; i < 7; i++) s += int'(fr[i]);
      e.cyc = drv_cyc + 2;
      if (fr[0] != 8'hA5)                         e.code = 8'h01;
      else if (fr[1] != 8'h01 && fr[1] != 8'h02)  e.code = 8'h02;
      else if ((s % 256) != int'(fr[7]))          e.code = 8'h03;
      else begin
        e.code  = 8'h00;
        e.wr    = (fr[1] == 8'h01);
        e.rd    = (fr[1] == 8'h02);
        e.addr  = fr[2];
        e.wdata = e.wr ? {fr[3], fr[4], fr[5], fr[6]} : 32'h0;
      end
    end
    if (e.code != 8'h00 && model_err < 65535) model_err++;
    e.errc = 16'(model_err);
    sb.push_back(e);
  endtask

  task automatic send(input logic udp, input logic [15:0] port, input bit with_last, input bit done_same);
    int n = fr.size();
    is_udp = udp;
    udp_dst_port = port;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk50);
      #1;
      udp_payload       = fr[i];
      udp_payload_valid = 1'b1;
      udp_payload_last  = with_last && (i == n - 1);
      frame_done        = done_same && (i == n - 1);
      if (i == n - 1) predict(udp, port, with_last, cyc);
      @(posedge clk50); #1;
      udp_payload_valid = 1'b0;
      udp_payload_last  = 1'b0;
      frame_done        = 1'b0;
    end
    if (!done_same) begin
      frame_done = 1'b1;
      @(posedge clk50); #1;
      frame_done = 1'b0;
    end
    repeat (6) @(posedge clk50);
  endtask

  task automatic rand_frame();
    int         n;
    logic [7:0] s, op;
    logic       udp;
    logic [15:0] port;
    bit         wl, ds;
    udp  = ($urandom_range(0, 19) != 0);
    port = ($urandom_range(0, 9) == 0) ? 16'd5005 : 16'd5006;
    n    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 11) : 8;
    fr.delete();
    fr.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hA5);
    case ($urandom_range(0, 5))
      0:       op = 8'($urandom);
      1, 2:    op = 8'h01;
      default: op = 8'h02;
    endcase
    fr.push_back(op);
    for (int i = 0; i < 5; i++) fr.push_back(8'($urandom));
    s = 8'h00;
    foreach (fr[i]) s = s + fr[i];
    fr.push_back(($urandom_range(0, 5) == 0) ? s + 8'h01 : s);
    while (fr.size() > n) void'(fr.pop_back());
    while (fr.size() < n) fr.push_back(8'($urandom));
    wl = ($urandom_range(0, 7) != 0);
    ds = wl && ($urandom_range(0, 1) == 1);
    send(udp, port, wl, ds);
  endtask

  // Monitor: every ack pulse is matched against the oldest prediction.
  always @(negedge clk50) begin
    exp_t e;
    if (!rst) begin
      if (ack_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", {24'h0, ack_code} | 32'h100, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("ack_code", {24'h0, ack_code}, {24'h0, e.code});
          chk("reg_wr", {31'h0, reg_wr}, {31'h0, e.wr});
          chk("reg_rd", {31'h0, reg_rd}, {31'h0, e.rd});
          chk("err_cnt", {16'h0, err_cnt}, {16'h0, e.errc});
          if (e.cyc >= 0) chk("latency_cycle", cyc, e.cyc);
          if (e.wr || e.rd) begin
            chk("reg_addr", {24'h0, reg_addr}, {24'h0, e.addr});
            chk("reg_wdata", reg_wdata, e.wdata);
          end
        end
      end else if (reg_wr || reg_rd) begin
        chk("stray_strobe", {30'h0, reg_wr, reg_rd}, 32'h0);
      end
    end
  end

  initial begin
    #(20 * 60000);
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk50);
    #1;
    chk("rst_reg_wr", {31'h0, reg_wr}, 32'h0);
    chk("rst_reg_rd", {31'h0, reg_rd}, 32'h0);
    chk("rst_ack_valid", {31'h0, ack_valid}, 32'h0);
    chk("rst_ack_code", {24'h0, ack_code}, 32'h0);
    chk("rst_reg_addr", {24'h0, reg_addr}, 32'h0);
    chk("rst_reg_wdata", reg_wdata, 32'h0);
    chk("rst_err_cnt", {16'h0, err_cnt}, 32'h0);
    chk("rst_wdog", {31'h0, wdog_timeout}, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk50);

`ifdef UDP_CMD_WDOG_EN
    repeat (105) @(posedge clk50);
    #1;
    chk("wdog_expired", {31'h0, wdog_timeout}, 32'h1);
`endif

    // Directed: valid WRITE, then error variants.
    fr = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h00, 8'h12, 8'h34, 8'hEE};
    send(1'b1, 16'd5006, 1'b1, 1'b0);
`ifdef UDP_CMD_WDOG_EN
    #1;
    chk("wdog_cleared", {31'h0, wdog_timeout}, 32'h0);
`endif
    fr = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h00, 8'h12, 8'h34, 8'hEF};
    send(1'b1, 16'd5006, 1'b1, 1'b1);
    fr = '{8'h5A, 8'h01, 8'h02, 8'h00, 8'h00, 8'h12, 8'h34, 8'hA3};
    send(1'b1, 16'd5006, 1'b1, 1'b0);
    fr = '{8'hA5, 8'h07, 8'h02, 8'h00, 8'h00, 8'h12, 8'h34, 8'hF4};
    send(1'b1, 16'd5006, 1'b1, 1'b0);
    fr = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h00, 8'h12, 8'h34};
    send(1'b1, 16'd5006, 1'b1, 1'b0);
    fr = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h00, 8'h12, 8'h34, 8'hEE, 8'h00};
    send(1'b1, 16'd5006, 1'b1, 1'b1);
    fr = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h00, 8'h12, 8'h34, 8'hEE};
    send(1'b1, 16'd5005, 1'b1, 1'b0);

    // Partial READ interrupted by reset, then a full READ.
    is_udp = 1'b1;
    udp_dst_port = 16'd5006;
    fr = '{8'hA5, 8'h02, 8'h10, 8'h00};
    foreach (fr[i]) begin
      @(posedge clk50); #1;
      udp_payload = fr[i];
      udp_payload_valid = 1'b1;
    end
    @(posedge clk50); #1;
    udp_payload_valid = 1'b0;
    rst = 1'b1;
    model_err = 0;
    repeat (2) @(posedge clk50);
    #1;
    chk("midpkt_rst_err_cnt", {16'h0, err_cnt}, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk50);
    fr = '{8'hA5, 8'h02, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB7};
    send(1'b1, 16'd5006, 1'b1, 1'b0);

    for (int k = 0; k < 80; k++) rand_frame();

    repeat (20) @(posedge clk50);
    #1;
    chk("scoreboard_drained", sb.size(), 32'h0);
`ifndef UDP_CMD_WDOG_EN
    chk("wdog_tied_low", {31'h0, wdog_timeout}, 32'h0);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
